// File: rtl/test_dma_host_port.sv
// Bench-side initiator for the DMA memory test device.
// TX channel: fills the device write ppfifo with an address-seeded
// incrementing pattern. RX channel: drains the device read ppfifo and
// checks it against the same pattern, resyncing after each mismatch.
module test_dma_host_port #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [63:0] tx_addr,
  input  logic [23:0] tx_count,
  output logic        tx_busy,
  output logic        tx_done,
  input  logic        rx_start,
  input  logic [63:0] rx_addr,
  input  logic [23:0] rx_count,
  output logic        rx_busy,
  output logic        rx_done,
  output logic        rx_error,
  output logic [23:0] rx_error_count,
  output logic        write_enable,
  output logic        write_addr_inc,
  output logic        write_addr_dec,
  output logic [63:0] write_addr,
  output logic [23:0] write_count,
  input  logic [1:0]  write_ready,
  output logic [1:0]  write_activate,
  input  logic [23:0] write_size,
  output logic        write_strobe,
  output logic [31:0] write_data,
  output logic        read_enable,
  output logic        read_addr_inc,
  output logic        read_addr_dec,
  output logic [63:0] read_addr,
  output logic [23:0] read_count,
  input  logic        read_ready,
  output logic        read_activate,
  input  logic [23:0] read_size,
  input  logic [31:0] read_data,
  output logic        read_strobe
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int PAD = 32 - AW;
  localparam logic [AW-1:0] PAT_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [23:0]   ERR_MAX = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GRAB = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // TX channel state
  state_t        tx_state_q;
  logic          tx_busy_q;
  logic          tx_done_q;
  logic          wr_en_q;
  logic [63:0]   wr_addr_q;
  logic [23:0]   wr_count_q;
  logic [1:0]    wr_act_q;
  logic          wr_strobe_q;
  logic [31:0]   wr_data_q;
  logic [AW-1:0] tx_pat_q;
  logic [23:0]   tx_remain_q;
  logic [23:0]   tx_chunk_q;

  // RX channel state
  state_t        rx_state_q;
  logic          rx_busy_q;
  logic          rx_done_q;
  logic          rx_error_q;
  logic [23:0]   rx_err_cnt_q;
  logic          rd_en_q;
  logic [63:0]   rd_addr_q;
  logic [23:0]   rd_count_q;
  logic          rd_act_q;
  logic          rd_strobe_q;
  logic [AW-1:0] rx_exp_q;
  logic [23:0]   rx_remain_q;
  logic [23:0]   rx_chunk_q;

  // Pattern arithmetic wraps naturally at AW bits.
  logic [AW-1:0] tx_pat_d;
  logic [AW-1:0] rx_exp_d;
  logic [AW-1:0] rx_resync_d;
  logic          rx_match_s;

  assign tx_pat_d    = tx_pat_q + PAT_ONE;
  assign rx_exp_d    = rx_exp_q + PAT_ONE;
  assign rx_resync_d = read_data[AW-1:0] + PAT_ONE;
  assign rx_match_s  = (read_data == {{PAD{1'b0}}, rx_exp_q});

  // TX FSM: latch request, grab a free write buffer, burst the pattern, release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= ST_IDLE;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 64'd0;
      wr_count_q  <= 24'd0;
      wr_act_q    <= 2'b00;
      wr_strobe_q <= 1'b0;
      wr_data_q   <= 32'd0;
      tx_pat_q    <= {AW{1'b0}};
      tx_remain_q <= 24'd0;
      tx_chunk_q  <= 24'd0;
    end else begin
      tx_done_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      case (tx_state_q)
        ST_IDLE: begin
          if (tx_start) begin
            if (tx_count == 24'd0) begin
              tx_done_q <= 1'b1;
            end else begin
              wr_addr_q   <= tx_addr;
              wr_count_q  <= tx_count;
              tx_pat_q    <= tx_addr[AW-1:0];
              tx_remain_q <= tx_count;
              wr_en_q     <= 1'b1;
              tx_busy_q   <= 1'b1;
              tx_state_q  <= ST_GRAB;
            end
          end
        end
        ST_GRAB: begin
          // Entered after every release; nothing left means the transfer is over.
          if (tx_remain_q == 24'd0) begin
            wr_en_q    <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b1;
            tx_state_q <= ST_IDLE;
          end else if ((wr_act_q == 2'b00) && (write_ready != 2'b00)) begin
            wr_act_q   <= write_ready[0] ? 2'b01 : 2'b10;
            tx_chunk_q <= 24'd0;
            tx_state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if ((tx_chunk_q < write_size) && (tx_remain_q != 24'd0)) begin
            wr_strobe_q <= 1'b1;
            wr_data_q   <= {{PAD{1'b0}}, tx_pat_q};
            tx_pat_q    <= tx_pat_d;
            tx_chunk_q  <= tx_chunk_q + 24'd1;
            tx_remain_q <= tx_remain_q - 24'd1;
          end else begin
            // Strobe is already low here, so release never shares a strobe cycle.
            wr_act_q   <= 2'b00;
            tx_state_q <= ST_GRAB;
          end
        end
        default: begin
          tx_state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // RX FSM: grab the read buffer, strobe words out, check each word in its strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= ST_IDLE;
      rx_busy_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_error_q   <= 1'b0;
      rx_err_cnt_q <= 24'd0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 64'd0;
      rd_count_q   <= 24'd0;
      rd_act_q     <= 1'b0;
      rd_strobe_q  <= 1'b0;
      rx_exp_q     <= {AW{1'b0}};
      rx_remain_q  <= 24'd0;
      rx_chunk_q   <= 24'd0;
    end else begin
      rx_done_q   <= 1'b0;
      rx_error_q  <= 1'b0;
      rd_strobe_q <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_start) begin
            if (rx_count == 24'd0) begin
              rx_done_q <= 1'b1;
            end else begin
              rd_addr_q    <= rx_addr;
              rd_count_q   <= rx_count;
              rx_exp_q     <= rx_addr[AW-1:0];
              rx_remain_q  <= rx_count;
              rx_err_cnt_q <= 24'd0;
              rd_en_q      <= 1'b1;
              rx_busy_q    <= 1'b1;
              rx_state_q   <= ST_GRAB;
            end
          end
        end
        ST_GRAB: begin
          if (rx_remain_q == 24'd0) begin
            rd_en_q    <= 1'b0;
            rx_busy_q  <= 1'b0;
            rx_done_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
          end else if (read_ready && !rd_act_q) begin
            rd_act_q   <= 1'b1;
            rx_chunk_q <= 24'd0;
            rx_state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // read_data is the word being popped whenever the strobe is high.
          if (rd_strobe_q) begin
            if (rx_match_s) begin
              rx_exp_q <= rx_exp_d;
            end else begin
              rx_error_q <= 1'b1;
              rx_exp_q   <= rx_resync_d;
              if (rx_err_cnt_q != ERR_MAX) begin
                rx_err_cnt_q <= rx_err_cnt_q + 24'd1;
              end
            end
          end
          if ((rx_chunk_q < read_size) && (rx_remain_q != 24'd0)) begin
            rd_strobe_q <= 1'b1;
            rx_chunk_q  <= rx_chunk_q + 24'd1;
            rx_remain_q <= rx_remain_q - 24'd1;
          end else begin
            rd_act_q   <= 1'b0;
            rx_state_q <= ST_GRAB;
          end
        end
        default: begin
          rx_state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy        = tx_busy_q;
  assign tx_done        = tx_done_q;
  assign write_enable   = wr_en_q;
  assign write_addr_inc = 1'b1;
  assign write_addr_dec = 1'b0;
  assign write_addr     = wr_addr_q;
  assign write_count    = wr_count_q;
  assign write_activate = wr_act_q;
  assign write_strobe   = wr_strobe_q;
  assign write_data     = wr_data_q;

  assign rx_busy        = rx_busy_q;
  assign rx_done        = rx_done_q;
  assign rx_error       = rx_error_q;
  assign rx_error_count = rx_err_cnt_q;
  assign read_enable    = rd_en_q;
  assign read_addr_inc  = 1'b1;
  assign read_addr_dec  = 1'b0;
  assign read_addr      = rd_addr_q;
  assign read_count     = rd_count_q;
  assign read_activate  = rd_act_q;
  assign read_strobe    = rd_strobe_q;

endmodule

// File: tb/tb_test_dma_host_port.sv
// Closed-loop bench: a device model with a 256-word memory, a two-buffer
// write ppfifo and a first-word-fall-through read ppfifo.
module tb_test_dma_host_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start, rx_start;
  logic [63:0] tx_addr, rx_addr;
  logic [23:0] tx_count, rx_count;
  logic        tx_busy, tx_done, rx_busy, rx_done, rx_error;
  logic [23:0] rx_error_count;
  logic        write_enable, write_addr_inc, write_addr_dec;
  logic [63:0] write_addr;
  logic [23:0] write_count;
  logic [1:0]  write_ready, write_activate;
  logic [23:0] write_size;
  logic        write_strobe;
  logic [31:0] write_data;
  logic        read_enable, read_addr_inc, read_addr_dec;
  logic [63:0] read_addr;
  logic [23:0] read_count;
  logic        read_ready, read_activate;
  logic [23:0] read_size;
  logic [31:0] read_data;
  logic        read_strobe;

  always #5 clk = ~clk;

  test_dma_host_port #(.ADDRESS_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .tx_start(tx_start), .tx_addr(tx_addr), .tx_count(tx_count),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_start(rx_start), .rx_addr(rx_addr), .rx_count(rx_count),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_error(rx_error),
    .rx_error_count(rx_error_count),
    .write_enable(write_enable), .write_addr_inc(write_addr_inc),
    .write_addr_dec(write_addr_dec), .write_addr(write_addr),
    .write_count(write_count), .write_ready(write_ready),
    .write_activate(write_activate), .write_size(write_size),
    .write_strobe(write_strobe), .write_data(write_data),
    .read_enable(read_enable), .read_addr_inc(read_addr_inc),
    .read_addr_dec(read_addr_dec), .read_addr(read_addr),
    .read_count(read_count), .read_ready(read_ready),
    .read_activate(read_activate), .read_size(read_size),
    .read_data(read_data), .read_strobe(read_strobe)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Device model and observation state
  logic [31:0] mem [256];
  logic [31:0] tx_words [$];
  int          tx_bufs [$];
  int          tx_chunks [$];
  int          rx_chunks [$];
  int          tx_done_cnt, rx_done_cnt, rx_err_pulses, rx_words_cnt;
  int          bad_strobe, bad_timing;
  int          drain_d = 2;
  logic [1:0]  wmask = 2'b11;
  logic [1:0]  wfree;
  logic        rfree;
  int          tx_base, rd_base, rd_idx, rd_pend;

  // Expected transfer parameters
  logic [63:0] e_tx_addr, e_rx_addr;
  int          e_tx_count, e_tx_size, e_rx_count, e_rx_size;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Device model: samples DUT outputs and drives ppfifo inputs on the falling edge.
  initial begin
    logic [1:0] pw;
    logic       pr, ps_w, ps_r, rel_w, rel_r;
    int         wcnt0, wcnt1, rcnt, cur_t, cur_r;
    pw = 2'b00; pr = 1'b0; ps_w = 1'b0; ps_r = 1'b0; rel_w = 1'b0; rel_r = 1'b0;
    wcnt0 = 0; wcnt1 = 0; rcnt = 0; cur_t = 0; cur_r = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wfree = 2'b11; rfree = 1'b1; pw = 2'b00; pr = 1'b0;
        ps_w = 1'b0; ps_r = 1'b0; rel_w = 1'b0; rel_r = 1'b0;
        wcnt0 = 0; wcnt1 = 0; rcnt = 0; cur_t = 0; cur_r = 0; rd_pend = 0;
      end else begin
        // observation
        if (write_strobe) begin
          mem[(tx_base + tx_words.size()) % 256] = write_data;
          tx_words.push_back(write_data);
          tx_bufs.push_back((write_activate == 2'b10) ? 1 : 0);
          cur_t++;
          if (write_activate != 2'b01 && write_activate != 2'b10) bad_strobe++;
        end
        if (pw != 2'b00 && write_activate == 2'b00) begin
          tx_chunks.push_back(cur_t);
          cur_t = 0;
          if (!ps_w) bad_timing++;
        end
        if (read_strobe) begin
          rx_words_cnt++;
          cur_r++;
          if (!read_activate) bad_strobe++;
        end
        if (pr && !read_activate) begin
          rx_chunks.push_back(cur_r);
          cur_r = 0;
          if (!ps_r) bad_timing++;
        end
        if (tx_done) begin
          tx_done_cnt++;
          if (tx_busy || write_enable) bad_timing++;
          if (tx_words.size() > 0 && !rel_w) bad_timing++;
        end
        if (rx_done) begin
          rx_done_cnt++;
          if (rx_busy || read_enable) bad_timing++;
          if (rx_words_cnt > 0 && !rel_r) bad_timing++;
        end
        if (rx_error) rx_err_pulses++;
        rel_w = (pw != 2'b00 && write_activate == 2'b00);
        rel_r = (pr && !read_activate);
        ps_w  = write_strobe;
        ps_r  = read_strobe;
        // write buffers: busy while activated, free drain_d cycles after release
        if (write_activate[0] && !pw[0]) wfree[0] = 1'b0;
        if (!write_activate[0] && pw[0]) wcnt0 = drain_d;
        else if (wcnt0 > 0) begin wcnt0--; if (wcnt0 == 0) wfree[0] = 1'b1; end
        if (write_activate[1] && !pw[1]) wfree[1] = 1'b0;
        if (!write_activate[1] && pw[1]) wcnt1 = drain_d;
        else if (wcnt1 > 0) begin wcnt1--; if (wcnt1 == 0) wfree[1] = 1'b1; end
        if (read_activate && !pr) rfree = 1'b0;
        if (!read_activate && pr) rcnt = drain_d;
        else if (rcnt > 0) begin rcnt--; if (rcnt == 0) rfree = 1'b1; end
        // read fifo pops the word shown during a strobe cycle
        rd_idx  = rd_idx + rd_pend;
        rd_pend = read_strobe ? 1 : 0;
        pw = write_activate;
        pr = read_activate;
      end
      write_ready = wfree & wmask;
      read_ready  = rfree;
      read_data   = mem[(rd_base + rd_idx) % 256];
    end
  end

  task automatic tx_prepare(input logic [63:0] a, input int cnt, input int sz,
                            input logic [1:0] m, input int d);
    repeat (12) @(negedge clk);
    e_tx_addr = a; e_tx_count = cnt; e_tx_size = sz;
    tx_addr = a; tx_count = cnt[23:0]; write_size = sz[23:0];
    wmask = m; drain_d = d; tx_base = int'(a[7:0]);
    tx_words.delete(); tx_bufs.delete(); tx_chunks.delete();
    tx_done_cnt = 0; bad_strobe = 0; bad_timing = 0;
  endtask

  task automatic rx_prepare(input logic [63:0] a, input int cnt, input int sz, input int d);
    repeat (12) @(negedge clk);
    e_rx_addr = a; e_rx_count = cnt; e_rx_size = sz;
    rx_addr = a; rx_count = cnt[23:0]; read_size = sz[23:0];
    drain_d = d; rd_base = int'(a[7:0]); rd_idx = 0;
    rx_chunks.delete();
    rx_done_cnt = 0; rx_err_pulses = 0; rx_words_cnt = 0; bad_strobe = 0; bad_timing = 0;
  endtask

  task automatic pulse_start(input bit do_tx, input bit do_rx);
    tx_start = do_tx; rx_start = do_rx;
    @(negedge clk);
    tx_start = 1'b0; rx_start = 1'b0;
    if (do_tx && e_tx_count > 0) begin
      check("tx_busy_rise", tx_busy, 1);
      check("wr_enable_rise", write_enable, 1);
      check("wr_addr_latch", write_addr, e_tx_addr);
      check("wr_count_latch", write_count, e_tx_count);
      check("wr_act_not_yet", write_activate, 0);
      check("wr_inc_dec", {write_addr_inc, write_addr_dec}, 2'b10);
    end else if (do_tx) begin
      check("tx_zero_done", tx_done, 1);
      check("tx_zero_busy", tx_busy, 0);
      check("tx_zero_enable", write_enable, 0);
    end
    if (do_rx && e_rx_count > 0) begin
      check("rx_busy_rise", rx_busy, 1);
      check("rd_enable_rise", read_enable, 1);
      check("rd_addr_latch", read_addr, e_rx_addr);
      check("rd_count_latch", read_count, e_rx_count);
      check("rx_errcnt_clear", rx_error_count, 0);
      check("rd_inc_dec", {read_addr_inc, read_addr_dec}, 2'b10);
    end else if (do_rx) begin
      check("rx_zero_done", rx_done, 1);
      check("rx_zero_enable", read_enable, 0);
    end
  endtask

  task automatic wait_done(input bit do_tx, input bit do_rx);
    int cyc = 0;
    while (((do_tx && tx_done_cnt == 0) || (do_rx && rx_done_cnt == 0)) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_within_budget", (cyc < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic tx_verify();
    int rem, j, exp_chunks [$];
    rem = e_tx_count;
    while (rem > 0) begin
      exp_chunks.push_back((rem < e_tx_size) ? rem : e_tx_size);
      rem -= (rem < e_tx_size) ? rem : e_tx_size;
    end
    check("tx_nwords", tx_words.size(), e_tx_count);
    for (int i = 0; i < tx_words.size() && i < e_tx_count; i++) begin
      check("tx_data", tx_words[i], (int'(e_tx_addr[7:0]) + i) % 256);
      j = i / e_tx_size;
      check("tx_buffer", tx_bufs[i], (wmask == 2'b01) ? 0 : (j % 2));
    end
    check("tx_nchunks", tx_chunks.size(), exp_chunks.size());
    for (int i = 0; i < tx_chunks.size() && i < exp_chunks.size(); i++)
      check("tx_chunk_len", tx_chunks[i], exp_chunks[i]);
    check("tx_done_once", tx_done_cnt, 1);
    check("tx_strobe_in_act", bad_strobe, 0);
    check("tx_timing", bad_timing, 0);
    check("tx_end_enable", write_enable, 0);
    check("tx_end_busy", tx_busy, 0);
  endtask

  task automatic rx_verify();
    int rem, errs, expv, exp_chunks [$];
    logic [31:0] d;
    rem = e_rx_count;
    while (rem > 0) begin
      exp_chunks.push_back((rem < e_rx_size) ? rem : e_rx_size);
      rem -= (rem < e_rx_size) ? rem : e_rx_size;
    end
    errs = 0;
    expv = int'(e_rx_addr[7:0]);
    for (int i = 0; i < e_rx_count; i++) begin
      d = mem[(int'(e_rx_addr[7:0]) + i) % 256];
      if (d != 32'(expv)) begin
        errs++;
        expv = (int'(d[7:0]) + 1) % 256;
      end else begin
        expv = (expv + 1) % 256;
      end
    end
    check("rx_nwords", rx_words_cnt, e_rx_count);
    check("rx_nchunks", rx_chunks.size(), exp_chunks.size());
    for (int i = 0; i < rx_chunks.size() && i < exp_chunks.size(); i++)
      check("rx_chunk_len", rx_chunks[i], exp_chunks[i]);
    check("rx_error_count", rx_error_count, errs);
    check("rx_error_pulses", rx_err_pulses, errs);
    check("rx_done_once", rx_done_cnt, 1);
    check("rx_strobe_in_act", bad_strobe, 0);
    check("rx_timing", bad_timing, 0);
    check("rx_end_enable", read_enable, 0);
    check("rx_end_busy", rx_busy, 0);
  endtask

  // Directed sequence followed by randomized closed-loop transfers.
  initial begin
    int cyc, a_idx, cnt, sz, rsz;
    logic [63:0] a;
    rst = 1'b1;
    tx_start = 1'b0; rx_start = 1'b0;
    tx_addr = 64'd0; rx_addr = 64'd0; tx_count = 24'd0; rx_count = 24'd0;
    write_size = 24'd0; read_size = 24'd0;
    write_ready = 2'b00; read_ready = 1'b0; read_data = 32'd0;
    tx_base = 0; rd_base = 0; rd_idx = 0; rd_pend = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    repeat (3) @(negedge clk);
    check("rst_wr_enable", write_enable, 0);
    check("rst_inc", {write_addr_inc, read_addr_inc}, 2'b11);
    check("rst_dec", {write_addr_dec, read_addr_dec}, 2'b00);
    check("rst_act", {write_activate, read_activate}, 3'b000);
    check("rst_strobe", {write_strobe, read_strobe}, 2'b00);
    check("rst_busy_done", {tx_busy, tx_done, rx_busy, rx_done, rx_error}, 5'd0);
    check("rst_err_cnt", rx_error_count, 0);
    check("rst_addr", write_addr | read_addr, 0);
    rst = 1'b0;

    // single buffer, short burst
    tx_prepare(64'h10, 4, 8, 2'b01, 3); pulse_start(1, 0); wait_done(1, 0); tx_verify();
    // pattern wrap
    tx_prepare(64'hFE, 4, 8, 2'b11, 3); pulse_start(1, 0); wait_done(1, 0); tx_verify();
    // multiple activations 8,8,4 alternating buffers
    tx_prepare(64'h20, 20, 8, 2'b11, 4); pulse_start(1, 0); wait_done(1, 0); tx_verify();
    // closed loop write then read across the wrap
    tx_prepare(64'hFC, 8, 8, 2'b11, 2); pulse_start(1, 0); wait_done(1, 0); tx_verify();
    rx_prepare(64'hFC, 8, 4, 2); pulse_start(0, 1); wait_done(0, 1); rx_verify();
    // corrupted word 3 (expected 0x13) in a 4-word read
    mem[8'h13] = 32'h0000_00AA;
    rx_prepare(64'h10, 4, 8, 2); pulse_start(0, 1); wait_done(0, 1); rx_verify();
    check("rx_corrupt_count", rx_error_count, 1);
    mem[8'h13] = 32'h0000_0013;
    rx_prepare(64'h10, 4, 8, 2); pulse_start(0, 1); wait_done(0, 1); rx_verify();
    // zero-length requests on both channels at once
    tx_prepare(64'h30, 0, 8, 2'b11, 2); rx_prepare(64'h30, 0, 4, 2);
    pulse_start(1, 1); wait_done(1, 1); tx_verify(); rx_verify();
    // simultaneous starts on disjoint regions
    tx_prepare(64'h1234_0000_0000_0080, 13, 5, 2'b11, 3);
    rx_prepare(64'h20, 11, 3, 3);
    pulse_start(1, 1); wait_done(1, 1); tx_verify(); rx_verify();
    // start while busy is ignored
    tx_prepare(64'h40, 20, 6, 2'b11, 2); pulse_start(1, 0);
    repeat (4) @(negedge clk);
    tx_addr = 64'h55; tx_count = 24'd3; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_start_addr", write_addr, 64'h40);
    check("busy_start_count", write_count, 20);
    wait_done(1, 0); tx_verify();
    // reset during a burst
    tx_prepare(64'h60, 20, 8, 2'b11, 3); pulse_start(1, 0);
    cyc = 0;
    while (!write_strobe && cyc < 200) begin @(negedge clk); cyc++; end
    check("saw_strobe_before_reset", write_strobe, 1);
    rst = 1'b1;
    #1;
    check("midrst_enable", write_enable, 0);
    check("midrst_act_strobe", {write_activate, write_strobe}, 3'b000);
    check("midrst_busy", tx_busy, 0);
    check("midrst_data_addr", write_data | write_addr[31:0], 0);
    check("midrst_inc", write_addr_inc, 1);
    @(negedge clk);
    rst = 1'b0;
    tx_prepare(64'h60, 6, 4, 2'b11, 2); pulse_start(1, 0); wait_done(1, 0); tx_verify();

    // randomized transfers, optionally with one corrupted word
    for (int it = 0; it < 8; it++) begin
      a   = {$urandom, $urandom};
      cnt = $urandom_range(1, 30);
      sz  = $urandom_range(1, 12);
      rsz = $urandom_range(1, 12);
      tx_prepare(a, cnt, sz, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11, $urandom_range(1, 6));
      pulse_start(1, 0); wait_done(1, 0); tx_verify();
      if ($urandom_range(0, 1) == 1) begin
        a_idx = (int'(a[7:0]) + $urandom_range(0, cnt - 1)) % 256;
        mem[a_idx] = $urandom;
      end
      rx_prepare(a, cnt, rsz, $urandom_range(1, 6));
      pulse_start(0, 1); wait_done(0, 1); rx_verify();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
